// File: rtl/sync_data_checker.sv
// sync_data_checker
//   Sink-side vector checker. Expected vectors are preloaded through a
//   ready/valid port into an internal buffer. After a start pulse, each
//   sample_en cycle compares the sample input against the next stored vector.
//   Mismatches are counted (saturating) and the first failing index is
//   recorded. Once the last vector has been compared, the checker parks in
//   DONE and reports pass/fail.
//
//   Optional feature (macro SYNC_DATA_CHECKER_MASK_EN):
//     Adds a per-vector load_mask. Bits with mask=0 are excluded from the
//     comparison. Without the macro, all WIDTH bits are compared.
//
// Ports:
//   clk, a_rst_n          clock (rising edge), asynchronous active-low reset
//   load_valid/load_data  expected-vector load stream
//   load_mask             per-vector compare mask (macro builds only)
//   load_ready            buffer can accept a vector (IDLE and not full)
//   start, clear          one-cycle control pulses; clear wins over everything
//   sample_en, sample     DUT output under check
//   busy, done, pass      run status; pass is valid while done=1
//   vec_count             number of vectors loaded
//   mismatch_count        saturating mismatch count
//   first_err_valid/idx   first failing vector index
//   err_pulse             registered one-cycle pulse per mismatch
module sync_data_checker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       a_rst_n,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
`ifdef SYNC_DATA_CHECKER_MASK_EN
  input  logic [WIDTH-1:0]           load_mask,
`endif
  output logic                       load_ready,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       sample_en,
  input  logic [WIDTH-1:0]           sample,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH):0]     vec_count,
  output logic [CNT_W-1:0]           mismatch_count,
  output logic                       first_err_valid,
  output logic [$clog2(DEPTH)-1:0]   first_err_idx,
  output logic                       err_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [AW:0] VecFull = DEPTH[AW:0];

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      vec_count_q, vec_count_d;
  logic [CNT_W-1:0] mismatch_q, mismatch_d;
  logic             fev_q, fev_d;
  logic [AW-1:0]    fei_q, fei_d;
  logic             err_pulse_q, err_pulse_d;

  // Expected-vector buffer; contents are don't-care after reset.
  logic [WIDTH-1:0] mem_data [DEPTH];
`ifdef SYNC_DATA_CHECKER_MASK_EN
  logic [WIDTH-1:0] mem_mask [DEPTH];
`endif

  // ---------------------------------------------------------------------------
  // Load handshake and compare datapath
  // ---------------------------------------------------------------------------
  logic             in_idle;
  logic             load_fire;
  logic [WIDTH-1:0] exp_data;
  logic [WIDTH-1:0] cmp_mask;
  logic             mismatch;
  logic [AW:0]      last_full;
  logic [AW-1:0]    last_idx;
  logic             is_last;

  assign in_idle    = (state_q == StIdle);
  assign load_ready = in_idle && (vec_count_q != VecFull);
  // A clear in the same cycle flushes the buffer, so the load is not taken.
  assign load_fire  = load_valid && load_ready && !clear;

  assign exp_data = mem_data[rd_ptr_q];
`ifdef SYNC_DATA_CHECKER_MASK_EN
  assign cmp_mask = mem_mask[rd_ptr_q];
`else
  assign cmp_mask = '1;
`endif
  assign mismatch = |((sample ^ exp_data) & cmp_mask);

  // Index of the final vector of this run; vec_count is never 0 in RUN.
  assign last_full = vec_count_q - 1'b1;
  assign last_idx  = last_full[AW-1:0];
  assign is_last   = (rd_ptr_q == last_idx);

  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_data[wr_ptr_q] <= load_data;
`ifdef SYNC_DATA_CHECKER_MASK_EN
      mem_mask[wr_ptr_q] <= load_mask;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    vec_count_d = vec_count_q;
    mismatch_d  = mismatch_q;
    fev_d       = fev_q;
    fei_d       = fei_q;
    err_pulse_d = 1'b0;

    if (clear) begin
      state_d     = StIdle;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      vec_count_d = '0;
      mismatch_d  = '0;
      fev_d       = 1'b0;
      fei_d       = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (load_fire) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            vec_count_d = vec_count_q + 1'b1;
          end
          if (start) begin
            rd_ptr_d   = '0;
            mismatch_d = '0;
            fev_d      = 1'b0;
            fei_d      = '0;
            // A load accepted alongside start is part of this run.
            state_d    = (vec_count_d != '0) ? StRun : StDone;
          end
        end

        StRun: begin
          if (sample_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (mismatch) begin
              err_pulse_d = 1'b1;
              if (mismatch_q != '1) begin
                mismatch_d = mismatch_q + 1'b1;
              end
              if (!fev_q) begin
                fev_d = 1'b1;
                fei_d = rd_ptr_q;
              end
            end
            if (is_last) begin
              state_d = StDone;
            end
          end
        end

        StDone: begin
          // Results held until clear.
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      vec_count_q <= '0;
      mismatch_q  <= '0;
      fev_q       <= 1'b0;
      fei_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      vec_count_q <= vec_count_d;
      mismatch_q  <= mismatch_d;
      fev_q       <= fev_d;
      fei_q       <= fei_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy            = (state_q == StRun);
  assign done            = (state_q == StDone);
  assign pass            = done && (mismatch_q == '0);
  assign vec_count       = vec_count_q;
  assign mismatch_count  = mismatch_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;
  assign err_pulse       = err_pulse_q;

endmodule

// File: tb/tb_sync_data_checker.sv
// Directed self-checking bench for sync_data_checker (WIDTH=8, DEPTH=16).
// Inputs change and outputs are observed on the falling clock edge.
module tb_sync_data_checker;

  localparam int unsigned W = 8;
  localparam int unsigned D = 16;
  localparam int unsigned C = 16;

  logic           clk = 1'b0;
  logic           a_rst_n;
  logic           load_valid;
  logic [W-1:0]   load_data;
`ifdef SYNC_DATA_CHECKER_MASK_EN
  logic [W-1:0]   load_mask;
`endif
  logic           load_ready;
  logic           start;
  logic           clear;
  logic           sample_en;
  logic [W-1:0]   sample;
  logic           busy;
  logic           done;
  logic           pass;
  logic [4:0]     vec_count;
  logic [C-1:0]   mismatch_count;
  logic           first_err_valid;
  logic [3:0]     first_err_idx;
  logic           err_pulse;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  sync_data_checker #(
    .WIDTH (W),
    .DEPTH (D),
    .CNT_W (C)
  ) dut (
    .clk             (clk),
    .a_rst_n         (a_rst_n),
    .load_valid      (load_valid),
    .load_data       (load_data),
`ifdef SYNC_DATA_CHECKER_MASK_EN
    .load_mask       (load_mask),
`endif
    .load_ready      (load_ready),
    .start           (start),
    .clear           (clear),
    .sample_en       (sample_en),
    .sample          (sample),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .vec_count       (vec_count),
    .mismatch_count  (mismatch_count),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .err_pulse       (err_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_vec(input logic [W-1:0] d, input logic [W-1:0] m);
    load_valid = 1'b1;
    load_data  = d;
`ifdef SYNC_DATA_CHECKER_MASK_EN
    load_mask  = m;
`else
    if (m == '0) load_data = d;  // mask unused in this build
`endif
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic smp(input logic [W-1:0] d);
    sample_en = 1'b1;
    sample    = d;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic load4(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] e);
    load_vec(a, 8'hFF);
    load_vec(b, 8'hFF);
    load_vec(c, 8'hFF);
    load_vec(e, 8'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int idx;
    logic [6:0] pat;
    logic [W-1:0] vecs [4];

    a_rst_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
`ifdef SYNC_DATA_CHECKER_MASK_EN
    load_mask  = '0;
`endif
    start      = 1'b0;
    clear      = 1'b0;
    sample_en  = 1'b0;
    sample     = '0;
    #1;
    check_eq("rst_load_ready", load_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_vec_count", vec_count, 0);
    check_eq("rst_mismatch", mismatch_count, 0);
    check_eq("rst_fev", first_err_valid, 0);
    check_eq("rst_err_pulse", err_pulse, 0);
    tick();
    tick();
    a_rst_n = 1'b1;
    tick();

    // All-match run
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    check_eq("t1_vec_count", vec_count, 4);
    pulse_start();
    check_eq("t1_busy", busy, 1);
    smp(8'h11);
    smp(8'h22);
    smp(8'h33);
    check_eq("t1_not_done", done, 0);
    smp(8'h44);
    check_eq("t1_done", done, 1);
    check_eq("t1_busy_low", busy, 0);
    check_eq("t1_pass", pass, 1);
    check_eq("t1_mismatch", mismatch_count, 0);
    check_eq("t1_fev", first_err_valid, 0);

    // Two mismatches at indices 1 and 3
    pulse_clear();
    check_eq("t2_cleared", vec_count, 0);
    load4(8'h11, 8'h22, 8'h33, 8'h44);
    pulse_start();
    pulses = 0;
    smp(8'h11); pulses += int'(err_pulse);
    smp(8'h20); pulses += int'(err_pulse);
    smp(8'h33); pulses += int'(err_pulse);
    smp(8'h40); pulses += int'(err_pulse);
    check_eq("t2_done", done, 1);
    tick();     pulses += int'(err_pulse);
    check_eq("t2_pulses", pulses, 2);
    check_eq("t2_mismatch", mismatch_count, 2);
    check_eq("t2_fei", first_err_idx, 1);
    check_eq("t2_fev", first_err_valid, 1);
    check_eq("t2_pass", pass, 0);

    // Overfill: 17 offers, 16 accepted
    pulse_clear();
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1;
      load_data  = (i == 16) ? 8'hEE : 8'(i + 1);
      if (i == 16) check_eq("t3_ready_low_17th", load_ready, 0);
      tick();
    end
    load_valid = 1'b0;
    check_eq("t3_vec_count", vec_count, 16);
    check_eq("t3_ready_low", load_ready, 0);
    pulse_start();
    for (int i = 0; i < 16; i++) smp(8'(i + 1));
    check_eq("t3_done", done, 1);
    check_eq("t3_pass", pass, 1);
    check_eq("t3_mismatch", mismatch_count, 0);

    // Stalls between enabled samples
    pulse_clear();
    vecs[0] = 8'hA0; vecs[1] = 8'hA1; vecs[2] = 8'hA2; vecs[3] = 8'hA3;
    load4(vecs[0], vecs[1], vecs[2], vecs[3]);
    pulse_start();
    pat = 7'b1101001;  // bit k = enable for step k: 1,0,0,1,0,1,1
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      if (pat[k]) begin
        sample_en = 1'b1;
        sample    = vecs[idx];
        idx++;
      end else begin
        sample_en = 1'b0;
        sample    = 8'hFF;
      end
      tick();
      if (k < 6) begin
        check_eq($sformatf("t4_busy_%0d", k), busy, 1);
        check_eq($sformatf("t4_ndone_%0d", k), done, 0);
      end
    end
    sample_en = 1'b0;
    check_eq("t4_done", done, 1);
    check_eq("t4_pass", pass, 1);
    pulse_clear();
    check_eq("t4_clr_busy", busy, 0);
    check_eq("t4_clr_done", done, 0);
    check_eq("t4_clr_vec_count", vec_count, 0);
    check_eq("t4_clr_ready", load_ready, 1);

    // Empty start
    pulse_start();
    check_eq("t5_empty_done", done, 1);
    check_eq("t5_empty_pass", pass, 1);

    // Asynchronous reset mid-run
    pulse_clear();
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    pulse_start();
    smp(8'h01);
    smp(8'h02);
    check_eq("t5_mid_busy", busy, 1);
    #2;
    a_rst_n = 1'b0;
    #1;
    check_eq("t5_arst_busy", busy, 0);
    check_eq("t5_arst_ready", load_ready, 1);
    check_eq("t5_arst_vec_count", vec_count, 0);
    check_eq("t5_arst_done", done, 0);
    tick();
    a_rst_n = 1'b1;
    tick();

    // Masked compare (mask only takes effect in macro builds)
    load_vec(8'h1F, 8'h0F);
    pulse_start();
    smp(8'h2F);
    check_eq("t6_done", done, 1);
`ifdef SYNC_DATA_CHECKER_MASK_EN
    check_eq("t6_mismatch", mismatch_count, 0);
    check_eq("t6_pass", pass, 1);
`else
    check_eq("t6_mismatch", mismatch_count, 1);
    check_eq("t6_pass", pass, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
